// File: rtl/freq_counter_bcd_if.sv
// Result handshake between the frequency counter and the display streamer.
// Signals:
//   digits    - packed BCD result, digit 0 in digits[3:0]
//   write_stb - result pending; transfer on write_stb & ready
//   ready     - consumer can accept a result
//   overflow  - window overflowed (only with FREQ_OVERFLOW_EN defined)
// Modports: master = counter side, slave = display side.
interface freq_counter_bcd_if #(
    parameter int unsigned DIGITS_NUM = 6
);
    logic [4*DIGITS_NUM-1:0] digits;
    logic                    write_stb;
    logic                    ready;
`ifdef FREQ_OVERFLOW_EN
    logic                    overflow;

    modport master (output digits, output write_stb, output overflow, input ready);
    modport slave  (input digits, input write_stb, input overflow, output ready);
`else
    modport master (output digits, output write_stb, input ready);
    modport slave  (input digits, input write_stb, output ready);
`endif
endinterface

// File: rtl/freq_counter_bcd.sv
// Gated frequency counter with a cascaded BCD count.
// Counts rising edges of an asynchronous input over GATE_CYCLES clocks and
// offers each window's result as packed BCD on a latest-wins handshake.
// Build option FREQ_OVERFLOW_EN: saturate at all-9s and report overflow;
// without it the count wraps modulo 10^DIGITS_NUM silently.
// Ports:
//   clk_in    - clock
//   reset_in  - asynchronous active-high reset
//   signal_in - measured signal, asynchronous to clk_in
//   enable    - 1 = measure, 0 = gate idle (pending result kept)
//   disp_if   - result handshake (digits/write_stb/ready[/overflow])
module freq_counter_bcd #(
    parameter int unsigned DIGITS_NUM  = 6,
    parameter int unsigned GATE_CYCLES = 12000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               signal_in,
    input  logic               enable,
    freq_counter_bcd_if.master disp_if
);

    localparam int unsigned BCD_W  = 4 * DIGITS_NUM;
    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_COUNT
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   edge_pulse;
    logic [GATE_W-1:0]      gate_q, gate_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [BCD_W-1:0]       bcd_next_c;
    logic                   carry_c;
    logic [BCD_W-1:0]       digits_q, digits_d;
    logic                   stb_q, stb_d;
`ifdef FREQ_OVERFLOW_EN
    logic                   win_ovf_q, win_ovf_d;
    logic                   ovf_q, ovf_d;
    logic                   sat_c;
`endif

    // Input synchronizer plus one flop for rising-edge detect
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~edge_q;

    // Cascaded BCD increment by edge_pulse; carry ripples through all digits
    always_comb begin
        bcd_next_c = bcd_q;
        carry_c    = edge_pulse;
        for (int i = 0; i < int'(DIGITS_NUM); i++) begin
            if (carry_c) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_next_c[4*i +: 4] = 4'd0;
                end else begin
                    bcd_next_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry_c              = 1'b0;
                end
            end
        end
`ifdef FREQ_OVERFLOW_EN
        // Carry out of the top digit means the count was all-9s: hold it there
        sat_c = carry_c;
        if (carry_c) begin
            bcd_next_c = bcd_q;
        end
`endif
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        gate_d   = gate_q;
        bcd_d    = bcd_q;
        digits_d = digits_q;
        stb_d    = stb_q;
`ifdef FREQ_OVERFLOW_EN
        win_ovf_d = win_ovf_q;
        ovf_d     = ovf_q;
`endif

        // Accept clears the pending flag; a new result below re-sets it
        if (stb_q && disp_if.ready) begin
            stb_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                gate_d = '0;
                bcd_d  = '0;
`ifdef FREQ_OVERFLOW_EN
                win_ovf_d = 1'b0;
`endif
                if (enable) begin
                    state_d = S_COUNT;
                end
            end

            S_COUNT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    gate_d  = '0;
                    bcd_d   = '0;
`ifdef FREQ_OVERFLOW_EN
                    win_ovf_d = 1'b0;
`endif
                end else if (gate_q == GATE_LAST) begin
                    // Terminal cycle: include this cycle's edge, restart with no gap
                    digits_d = bcd_next_c;
                    stb_d    = 1'b1;
                    gate_d   = '0;
                    bcd_d    = '0;
`ifdef FREQ_OVERFLOW_EN
                    ovf_d     = win_ovf_q | sat_c;
                    win_ovf_d = 1'b0;
`endif
                end else begin
                    gate_d = gate_q + GATE_W'(1);
                    bcd_d  = bcd_next_c;
`ifdef FREQ_OVERFLOW_EN
                    win_ovf_d = win_ovf_q | sat_c;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= S_IDLE;
            gate_q   <= '0;
            bcd_q    <= '0;
            digits_q <= '0;
            stb_q    <= 1'b0;
`ifdef FREQ_OVERFLOW_EN
            win_ovf_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gate_q   <= gate_d;
            bcd_q    <= bcd_d;
            digits_q <= digits_d;
            stb_q    <= stb_d;
`ifdef FREQ_OVERFLOW_EN
            win_ovf_q <= win_ovf_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign disp_if.digits    = digits_q;
    assign disp_if.write_stb = stb_q;
`ifdef FREQ_OVERFLOW_EN
    assign disp_if.overflow  = ovf_q;
`endif

endmodule
